bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit that applies one of eight selectable per-bit boolean operations to two WIDTH-bit operands. It also has an optional accumulate mode that replaces operand A with an internal accumulator. It sits on a valid/ready stream inside the gate-level logic datapath. It replaces fixed per-bit gate networks with a single configurable, back-pressurable block.

---
 rtl/bitwise_logic_pipe.sv | 186 ++++++++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_logic_pipe
//
// Two-stage, back-pressurable bitwise logic unit. Each accepted beat applies
// one of eight per-bit boolean operations to two WIDTH-bit operands. In
// accumulate mode the internal accumulator takes the place of operand A, and
// the result is written back into the accumulator.
//
// Stage p1 holds the accepted beat {op, acc_mode, a, b}.
// Stage p2 holds the evaluated result {y, zero, parity}.
// Evaluation happens on the p1 -> p2 transfer, and so does the accumulator
// read/update. Back-to-back accumulate beats therefore chain correctly.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 1)
//   ACC_EN  1 = accumulator present; 0 = acc_mode/acc_clear have no effect
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat offered
//   in_ready   block can take a beat this cycle (combinational from out_ready)
//   op         opcode: 000 AND, 001 OR, 010 XOR, 011 NAND,
//              100 NOR, 101 XNOR, 110 PASS_A, 111 PASS_B
//   acc_mode   use accumulator in place of a for this beat
//   a, b       operands
//   acc_clear  synchronous accumulator clear (wins over an accumulate update)
//   out_valid  result beat valid
//   out_ready  downstream takes the result
//   y          result
//   zero       y == 0
//   parity     XOR-reduction of y
// ---------------------------------------------------------------------------
module bitwise_logic_pipe #(
    parameter int WIDTH  = 4,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_NAND   = 3'b011;
    localparam logic [2:0] OP_NOR    = 3'b100;
    localparam logic [2:0] OP_XNOR   = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_PASS_B = 3'b111;

    // Per-bit boolean operation; no carries, result is exactly WIDTH bits.
    function automatic logic [WIDTH-1:0] eval_op(
        input logic [2:0]       op_sel,
        input logic [WIDTH-1:0] opd_a,
        input logic [WIDTH-1:0] opd_b
    );
        logic [WIDTH-1:0] r;
        case (op_sel)
            OP_AND:    r = opd_a & opd_b;
            OP_OR:     r = opd_a | opd_b;
            OP_XOR:    r = opd_a ^ opd_b;
            OP_NAND:   r = ~(opd_a & opd_b);
            OP_NOR:    r = ~(opd_a | opd_b);
            OP_XNOR:   r = ~(opd_a ^ opd_b);
            OP_PASS_A: r = opd_a;
            OP_PASS_B: r = opd_b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Stage p1 registers
    logic             vld_p1;
    logic [2:0]       op_p1;
    logic             acc_mode_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;

    // Stage p2 registers
    logic             vld_p2;
    logic [WIDTH-1:0] y_p2;
    logic             zero_p2;
    logic             parity_p2;

    logic [WIDTH-1:0] acc_q;

    logic             s2_adv;
    logic             xfer;
    logic             accept;
    logic             use_acc;
    logic [WIDTH-1:0] opa_p1;
    logic [WIDTH-1:0] res_p1;

    // Flow control: no skid buffer, so in_ready depends on out_ready.
    assign s2_adv   = !vld_p2 || out_ready;
    assign xfer     = vld_p1 && s2_adv;
    assign in_ready = !vld_p1 || s2_adv;
    assign accept   = in_valid && in_ready;

    // Accumulator read happens at the transfer edge, so it sees any update
    // made by the previous beat's transfer one edge earlier.
    assign use_acc = (ACC_EN != 0) && acc_mode_p1;
    assign opa_p1  = use_acc ? acc_q : a_p1;
    assign res_p1  = eval_op(op_p1, opa_p1, b_p1);

    // ---- stage p1: capture accepted beat ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1       <= op;
            acc_mode_p1 <= acc_mode;
            a_p1        <= a;
            b_p1        <= b;
        end
    end

    // ---- stage p2: evaluated result, held while stalled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            y_p2      <= '0;
            zero_p2   <= 1'b0;
            parity_p2 <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2      <= res_p1;
                zero_p2   <= is_zero(res_p1);
                parity_p2 <= parity_of(res_p1);
            end
        end
    end

    // ---- accumulator ----
    generate
        if (ACC_EN != 0) begin : g_acc
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (acc_clear) begin
                    // Clear wins; the transferring beat already used the old value.
                    acc_q <= '0;
                end else if (xfer && acc_mode_p1) begin
                    acc_q <= res_p1;
                end
            end
        end else begin : g_no_acc
            assign acc_q = '0;
        end
    endgenerate

    assign out_valid = vld_p2;
    assign y         = y_p2;
    assign zero      = zero_p2;
    assign parity    = parity_p2;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: three instances (4-bit with accumulator,
// 4-bit without accumulator, 32-bit with accumulator) share one stimulus.
// A transaction-level model predicts every output each cycle; directed
// sequences also pin hand-computed results.
module tb_bitwise_logic_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        acc_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        acc_clear = 1'b0;
    logic        out_ready = 1'b1;

    logic       rdy4, vld4, z4, p4;
    logic [3:0] y4;
    logic       rdyn, vldn, zn, pn;
    logic [3:0] yn;
    logic        rdy32, vld32, z32, p32;
    logic [31:0] y32;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(4), .ACC_EN(1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .op(op),
        .acc_mode(acc_mode), .a(a[3:0]), .b(b[3:0]), .acc_clear(acc_clear),
        .out_valid(vld4), .out_ready(out_ready), .y(y4), .zero(z4), .parity(p4));

    bitwise_logic_pipe #(.WIDTH(4), .ACC_EN(0)) dutn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyn), .op(op),
        .acc_mode(acc_mode), .a(a[3:0]), .b(b[3:0]), .acc_clear(acc_clear),
        .out_valid(vldn), .out_ready(out_ready), .y(yn), .zero(zn), .parity(pn));

    bitwise_logic_pipe #(.WIDTH(32), .ACC_EN(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .op(op),
        .acc_mode(acc_mode), .a(a), .b(b), .acc_clear(acc_clear),
        .out_valid(vld32), .out_ready(out_ready), .y(y32), .zero(z32), .parity(p32));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return x;
            default: return z;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int k);
        return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_000F;
    endfunction

    // Per instance: a waiting (unevaluated) beat and a presented result.
    bit          mp_v[3];
    logic [2:0]  mp_op[3];
    bit          mp_am[3];
    logic [31:0] mp_a[3];
    logic [31:0] mp_b[3];
    bit          mo_v[3];
    logic [31:0] mo_y[3];
    bit          mo_z[3];
    bit          mo_p[3];
    logic [31:0] macc[3];
    bit          m_drain, m_room, m_take, m_use;
    logic [31:0] m_old, m_r;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mp_v[k] = 0; mo_v[k] = 0; mo_y[k] = '0; mo_z[k] = 0; mo_p[k] = 0; macc[k] = '0;
            end else begin
                m_drain = mo_v[k] && out_ready;
                m_room  = !mo_v[k] || out_ready;
                m_take  = in_valid && (!mp_v[k] || m_room);
                m_old   = macc[k];
                if (acc_clear && k != 1) macc[k] = '0;
                if (m_drain) mo_v[k] = 0;
                if (mp_v[k] && m_room) begin
                    m_use = (k != 1) && mp_am[k];
                    m_r = ref_op(mp_op[k], m_use ? m_old : mp_a[k], mp_b[k]) & wmask(k);
                    mo_v[k] = 1; mo_y[k] = m_r; mo_z[k] = (m_r == 0); mo_p[k] = ^m_r;
                    if (m_use && !acc_clear) macc[k] = m_r;
                    mp_v[k] = 0;
                end
                if (m_take) begin
                    mp_v[k] = 1; mp_op[k] = op; mp_am[k] = acc_mode;
                    mp_a[k] = a & wmask(k); mp_b[k] = b & wmask(k);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    logic [31:0] d_y[3];
    logic        d_v[3], d_z[3], d_p[3], d_r[3];
    always_comb begin
        d_y[0] = {28'd0, y4};  d_v[0] = vld4;  d_z[0] = z4;  d_p[0] = p4;  d_r[0] = rdy4;
        d_y[1] = {28'd0, yn};  d_v[1] = vldn;  d_z[1] = zn;  d_p[1] = pn;  d_r[1] = rdyn;
        d_y[2] = y32;          d_v[2] = vld32; d_z[2] = z32; d_p[2] = p32; d_r[2] = rdy32;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model out_valid[%0d]", k), {31'd0, d_v[k]}, {31'd0, mo_v[k]});
                check($sformatf("model y[%0d]", k), d_y[k], mo_y[k]);
                check($sformatf("model zero[%0d]", k), {31'd0, d_z[k]}, {31'd0, mo_z[k]});
                check($sformatf("model parity[%0d]", k), {31'd0, d_p[k]}, {31'd0, mo_p[k]});
                check($sformatf("model in_ready[%0d]", k), {31'd0, d_r[k]},
                      {31'd0, (!mp_v[k] || !mo_v[k] || out_ready)});
            end
        end
    end

    // Log of delivered results {parity, zero, y} and accepted beat count.
    logic [33:0] got4[$];
    logic [33:0] got32[$];
    int          acc_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (vld4 && out_ready)  got4.push_back({p4, z4, 28'd0, y4});
            if (vld32 && out_ready) got32.push_back({p32, z32, y32});
            if (in_valid && rdy4)   acc_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [2:0] o, input logic m, input logic [31:0] av, input logic [31:0] bv);
        logic ok;
        int   n;
        n = 0;
        in_valid = 1'b1; op = o; acc_mode = m; a = av; b = bv;
        forever begin
            @(negedge clk);
            ok = rdy4;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 50) begin
                check("send timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        acc_clear = 1'b1;
        tick(1);
        acc_clear = 1'b0;
    endtask

    task automatic pin4(input string nm, input int idx, input logic [3:0] ey, input logic ez, input logic ep);
        if (idx >= got4.size()) begin
            check({nm, " missing"}, 32'd0, 32'd1);
        end else begin
            check({nm, " y"}, got4[idx][31:0], {28'd0, ey});
            check({nm, " zero"}, {31'd0, got4[idx][32]}, {31'd0, ez});
            check({nm, " parity"}, {31'd0, got4[idx][33]}, {31'd0, ep});
        end
    endtask

    localparam logic [3:0] SWEEP_Y[8] = '{4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'hC, 4'hA};
    localparam logic       SWEEP_P[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int base;
        int cnt0;

        // Reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset out_valid", {31'd0, vld4}, 32'd0);
        check("reset y", {28'd0, y4}, 32'd0);
        check("reset zero", {31'd0, z4}, 32'd0);
        check("reset parity", {31'd0, p4}, 32'd0);
        check("reset in_ready", {31'd0, rdy4}, 32'd1);

        // Op sweep, back-to-back, out_ready held high
        out_ready = 1'b1;
        base = got4.size();
        for (int i = 0; i < 8; i++) begin
            send(i[2:0], 1'b0, 32'hC, 32'hA);
            if (i == 0) check("latency out_valid after accept edge", {31'd0, vld4}, 32'd0);
            if (i == 1) begin
                check("latency out_valid next edge", {31'd0, vld4}, 32'd1);
                check("latency first y", {28'd0, y4}, 32'h8);
            end
        end
        tick(4);
        for (int i = 0; i < 8; i++)
            pin4($sformatf("sweep op%0d", i), base + i, SWEEP_Y[i], (SWEEP_Y[i] == 4'h0), SWEEP_P[i]);

        // Backpressure: 6 PASS_B beats while out_ready is low for 5 cycles
        base = got4.size();
        cnt0 = acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(3'b111, 1'b0, 32'h0, i);
            end
            begin
                tick(5);
                check("stall acceptances", acc_cnt - cnt0, 32'd2);
                check("stall in_ready", {31'd0, rdy4}, 32'd0);
                out_ready = 1'b1;
            end
        join
        tick(4);
        check("stall result count", got4.size() - base, 32'd6);
        for (int i = 0; i < 6; i++)
            pin4($sformatf("stall beat%0d", i), base + i, i[3:0] + 4'd1, 1'b0, ^(i[3:0] + 4'd1));

        // Accumulate chain
        pulse_clear();
        base = got4.size();
        send(3'b010, 1'b1, 32'h0, 32'h3);
        send(3'b010, 1'b1, 32'h0, 32'h5);
        send(3'b010, 1'b1, 32'h0, 32'hF);
        send(3'b001, 1'b0, 32'h0, 32'hF);
        send(3'b110, 1'b1, 32'h0, 32'h0);
        tick(4);
        pin4("acc xor1", base + 0, 4'h3, 1'b0, 1'b0);
        pin4("acc xor2", base + 1, 4'h6, 1'b0, 1'b0);
        pin4("acc xor3", base + 2, 4'h9, 1'b0, 1'b0);
        pin4("acc non-acc or", base + 3, 4'hF, 1'b0, 1'b0);
        pin4("acc readback", base + 4, 4'h9, 1'b0, 1'b0);

        // Clear colliding with an accumulate transfer
        pulse_clear();
        base = got4.size();
        send(3'b010, 1'b1, 32'h0, 32'h6);
        send(3'b010, 1'b1, 32'h0, 32'h1);
        acc_clear = 1'b1;
        tick(1);
        acc_clear = 1'b0;
        send(3'b110, 1'b1, 32'h0, 32'h0);
        tick(4);
        pin4("collide setup", base + 0, 4'h6, 1'b0, 1'b0);
        pin4("collide y old acc", base + 1, 4'h7, 1'b0, 1'b1);
        pin4("collide acc cleared", base + 2, 4'h0, 1'b1, 1'b0);

        // Reset with two beats in flight
        send(3'b010, 1'b1, 32'h0, 32'hA);
        tick(4);
        out_ready = 1'b0;
        send(3'b111, 1'b0, 32'h0, 32'h5);
        send(3'b111, 1'b0, 32'h0, 32'h9);
        base = got4.size();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset out_valid", {31'd0, vld4}, 32'd0);
        check("midreset y", {28'd0, y4}, 32'd0);
        check("midreset in_ready", {31'd0, rdy4}, 32'd1);
        out_ready = 1'b1;
        send(3'b110, 1'b1, 32'h0, 32'h0);
        tick(4);
        check("midreset result count", got4.size() - base, 32'd1);
        pin4("midreset acc zero", base, 4'h0, 1'b1, 1'b0);

        // 32-bit operands
        base = got32.size();
        send(3'b011, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
        send(3'b000, 1'b0, 32'hFFFF_0000, 32'h0000_FFFF);
        tick(4);
        if (got32.size() < base + 2) begin
            check("w32 missing", 32'd0, 32'd1);
        end else begin
            check("w32 nand y", got32[base][31:0], 32'hF0F0_FFFF);
            check("w32 nand zero", {31'd0, got32[base][32]}, 32'd0);
            check("w32 and y", got32[base + 1][31:0], 32'h0000_0000);
            check("w32 and zero", {31'd0, got32[base + 1][32]}, 32'd1);
            check("w32 and parity", {31'd0, got32[base + 1][33]}, 32'd0);
        end

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
